lbp_host_mem: RTL and testbench

Host-side memory model and responder for the LBP engine's gray/lbp interface. Holds the gray image and the LBP result image. Serves gray pixel reads. Captures LBP result writes. After the engine raises finish, streams the full result image out over a valid/ready port. Sits opposite the LBP engine in the 128x128 image subsystem; its image is loaded beforehand through a simple write port.

---
 rtl/lbp_host_mem_if.sv | 55 +++++
 rtl/lbp_host_mem.sv | 198 +++++++++++++++++++
 tb/tb_lbp_host_mem.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/lbp_host_mem_if.sv
// Signal bundle between the LBP engine side (master) and the host memory
// model (slave): image load port, gray read port, result writes and dump stream.
interface lbp_host_mem_if #(
    parameter int XW = 7,
    parameter int DW = 8
);
    localparam int AW = 2 * XW;

    logic          load_valid;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          load_last;

    logic          gray_ready;
    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic [DW-1:0] gray_data;

    logic          lbp_valid;
    logic [AW-1:0] lbp_addr;
    logic [DW-1:0] lbp_data;
    logic          finish;

    // Dump stream: a beat transfers on any rising edge where out_valid and
    // out_ready are both high; while out_valid=1 and out_ready=0 the source
    // holds out_addr/out_data unchanged and keeps out_valid high.
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;

    logic          dump_done;
    logic [AW:0]   wr_count;
    logic          err;

    modport slave (
        input  load_valid, load_addr, load_data, load_last,
        input  gray_req, gray_addr,
        input  lbp_valid, lbp_addr, lbp_data, finish,
        input  out_ready,
        output gray_ready, gray_data,
        output out_valid, out_addr, out_data,
        output dump_done, wr_count, err
    );

    modport master (
        output load_valid, load_addr, load_data, load_last,
        output gray_req, gray_addr,
        output lbp_valid, lbp_addr, lbp_data, finish,
        output out_ready,
        input  gray_ready, gray_data,
        input  out_valid, out_addr, out_data,
        input  dump_done, wr_count, err
    );
endinterface

// File: rtl/lbp_host_mem.sv
// Host-side memory model for the LBP engine: loads the gray image, serves
// falling-edge pixel reads, captures LBP results and streams them out.
module lbp_host_mem #(
    parameter int XW = 7,
    parameter int DW = 8
) (
    input  logic           clk,
    input  logic           reset,
    lbp_host_mem_if.slave  bus,
    output logic [1:0]     dbg_state
);
    localparam int AW    = 2 * XW;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SERVE = 2'd1,
        DUMP  = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic logic is_border(input logic [AW-1:0] a);
        logic [XW-1:0] r;
        logic [XW-1:0] c;
        r = a[AW-1:XW];
        c = a[XW-1:0];
        return (r == '0) || (r == '1) || (c == '0) || (c == '1);
    endfunction

    logic [DW-1:0] gray_mem [DEPTH];
    logic [DW-1:0] lbp_mem  [DEPTH];

    state_e        state_q,      state_d;
    logic          gray_ready_q, gray_ready_d;
    logic [DW-1:0] gray_data_q;
    logic [AW:0]   wr_count_q,   wr_count_d;
    logic          err_q,        err_d;
    logic          dump_done_q,  dump_done_d;

    logic          out_valid_q,  out_valid_d;
    logic [AW-1:0] out_addr_q,   out_addr_d;
    logic [DW-1:0] out_data_q,   out_data_d;
    logic          pf_valid_q,   pf_valid_d;
    logic [AW-1:0] pf_addr_q,    pf_addr_d;
    logic [DW-1:0] pf_data_q,    pf_data_d;
    logic          rd_pend_q,    rd_pend_d;
    logic [AW-1:0] rd_addr_q,    rd_addr_d;
    logic [AW:0]   issue_ptr_q,  issue_ptr_d;
    logic [DW-1:0] ram_dout_q;

    logic          in_load, in_serve, in_dump;
    logic          load_we, lbp_we, issue, pop;
    logic [2:0]    occ;
    logic [DW-1:0] arrive_data;

    always_comb begin
        state_d      = state_q;
        wr_count_d   = wr_count_q;
        err_d        = err_q;
        out_valid_d  = out_valid_q;
        out_addr_d   = out_addr_q;
        out_data_d   = out_data_q;
        pf_valid_d   = pf_valid_q;
        pf_addr_d    = pf_addr_q;
        pf_data_d    = pf_data_q;
        rd_pend_d    = 1'b0;
        rd_addr_d    = rd_addr_q;
        issue_ptr_d  = issue_ptr_q;
        issue        = 1'b0;
        in_load      = (state_q == LOAD);
        in_serve     = (state_q == SERVE);
        in_dump      = (state_q == DUMP);
        load_we      = bus.load_valid && in_load;
        lbp_we       = bus.lbp_valid && in_serve;
        pop          = out_valid_q && bus.out_ready;
        arrive_data  = is_border(rd_addr_q) ? '0 : ram_dout_q;

        case (state_q)
            LOAD:    if (bus.load_valid && bus.load_last) state_d = SERVE;
            SERVE:   if (bus.finish) state_d = DUMP;
            DUMP:    if (pop && (out_addr_q == '1)) state_d = DONE;
            default: state_d = state_q;
        endcase

        err_d = err_q
              | (bus.load_valid && !in_load)
              | (bus.lbp_valid  && !in_serve)
              | (bus.gray_req   && !in_serve)
              | (lbp_we && is_border(bus.lbp_addr));

        // wr_count reaching 2^AW sets its top bit, which is the saturation point.
        if (lbp_we && !wr_count_q[AW]) wr_count_d = wr_count_q + 1'b1;

        // Two output slots (out, pf); a read may be launched only if the slot it
        // lands in next cycle is guaranteed free, so at most one slot may be held.
        occ   = 3'(out_valid_q) + 3'(pf_valid_q) + 3'(rd_pend_q) - 3'(pop);
        issue = in_dump && !issue_ptr_q[AW] && (occ <= 3'd1);
        if (issue) begin
            rd_pend_d   = 1'b1;
            rd_addr_d   = issue_ptr_q[AW-1:0];
            issue_ptr_d = issue_ptr_q + 1'b1;
        end

        if (in_dump) begin
            if (!out_valid_q || pop) begin
                if (pf_valid_q) begin
                    out_valid_d = 1'b1;
                    out_addr_d  = pf_addr_q;
                    out_data_d  = pf_data_q;
                    pf_valid_d  = rd_pend_q;
                    if (rd_pend_q) begin
                        pf_addr_d = rd_addr_q;
                        pf_data_d = arrive_data;
                    end
                end else if (rd_pend_q) begin
                    out_valid_d = 1'b1;
                    out_addr_d  = rd_addr_q;
                    out_data_d  = arrive_data;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (rd_pend_q) begin
                pf_valid_d = 1'b1;
                pf_addr_d  = rd_addr_q;
                pf_data_d  = arrive_data;
            end
        end else begin
            out_valid_d = 1'b0;
            pf_valid_d  = 1'b0;
        end

        gray_ready_d = (state_d == SERVE);
        dump_done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= LOAD;
            gray_ready_q <= 1'b0;
            wr_count_q   <= '0;
            err_q        <= 1'b0;
            dump_done_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_addr_q   <= '0;
            out_data_q   <= '0;
            pf_valid_q   <= 1'b0;
            pf_addr_q    <= '0;
            pf_data_q    <= '0;
            rd_pend_q    <= 1'b0;
            rd_addr_q    <= '0;
            issue_ptr_q  <= '0;
        end else begin
            state_q      <= state_d;
            gray_ready_q <= gray_ready_d;
            wr_count_q   <= wr_count_d;
            err_q        <= err_d;
            dump_done_q  <= dump_done_d;
            out_valid_q  <= out_valid_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
            pf_valid_q   <= pf_valid_d;
            pf_addr_q    <= pf_addr_d;
            pf_data_q    <= pf_data_d;
            rd_pend_q    <= rd_pend_d;
            rd_addr_q    <= rd_addr_d;
            issue_ptr_q  <= issue_ptr_d;
        end
    end

    // Image memories are intentionally not reset.
    always_ff @(posedge clk) begin
        if (load_we) gray_mem[bus.load_addr] <= bus.load_data;
    end

    always_ff @(posedge clk) begin
        if (lbp_we) lbp_mem[bus.lbp_addr] <= bus.lbp_data;
        if (issue)  ram_dout_q <= lbp_mem[issue_ptr_q[AW-1:0]];
    end

    // Falling-edge read gives the engine a full half cycle of setup to its next rising edge.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            gray_data_q <= '0;
        end else if (bus.gray_req && (state_q == SERVE)) begin
            gray_data_q <= gray_mem[bus.gray_addr];
        end
    end

    assign bus.gray_ready = gray_ready_q;
    assign bus.gray_data  = gray_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_addr   = out_addr_q;
    assign bus.out_data   = out_data_q;
    assign bus.dump_done  = dump_done_q;
    assign bus.wr_count   = wr_count_q;
    assign bus.err        = err_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_lbp_host_mem.sv
// Directed bench for lbp_host_mem: load, falling-edge reads, result capture,
// border masking, dump under backpressure and reset mid-dump.
module tb_lbp_host_mem;
    localparam int XW = 7;
    localparam int DW = 8;
    localparam int AW = 2 * XW;
    localparam int N  = 1 << AW;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    lbp_host_mem_if #(.XW(XW), .DW(DW)) bus ();

    lbp_host_mem #(.XW(XW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          req;
        logic [DW-1:0] exp;
    } rd_vec_t;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] lbp_model [N];
    logic [DW-1:0] exp_q [$];
    rd_vec_t       rd_tab [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit border(input int a);
        int r, c;
        r = a / 128;
        c = a % 128;
        return (r == 0) || (r == 127) || (c == 0) || (c == 127);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.load_valid = 0; bus.load_addr = '0; bus.load_data = '0; bus.load_last = 0;
        bus.gray_req = 0;   bus.gray_addr = '0;
        bus.lbp_valid = 0;  bus.lbp_addr = '0;  bus.lbp_data = '0;
        bus.finish = 0;     bus.out_ready = 0;
    endtask

    task automatic load_beat(input int a, input logic [DW-1:0] d, input bit last);
        bus.load_valid = 1; bus.load_addr = AW'(a); bus.load_data = d; bus.load_last = last;
        tick();
        bus.load_valid = 0; bus.load_last = 0;
    endtask

    task automatic lbp_write(input int a, input logic [DW-1:0] d, input bit fin);
        bus.lbp_valid = 1; bus.lbp_addr = AW'(a); bus.lbp_data = d; bus.finish = fin;
        tick();
        bus.lbp_valid = 0; bus.finish = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        idle_inputs();
        #1;
        chk("rst_gray_ready", bus.gray_ready, 0);
        chk("rst_gray_data",  bus.gray_data, 0);
        chk("rst_out_valid",  bus.out_valid, 0);
        chk("rst_out_addr",   bus.out_addr, 0);
        chk("rst_out_data",   bus.out_data, 0);
        chk("rst_dump_done",  bus.dump_done, 0);
        chk("rst_wr_count",   bus.wr_count, 0);
        chk("rst_err",        bus.err, 0);
        chk("rst_state",      dbg_state, 0);
        @(negedge clk);
        reset = 0;
        tick();
    endtask

    // Streams the dump starting from the first DUMP cycle until stop_addr is accepted.
    task automatic run_dump(input bit toggle, input int stop_addr);
        int            exp_addr;
        int            first_valid;
        bit            done;
        logic          p_valid, p_ready;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_data;
        exp_q.delete();
        for (int a = 0; a <= stop_addr; a++) exp_q.push_back(border(a) ? 8'h00 : lbp_model[a]);
        exp_addr = 0; first_valid = -1; done = 0; p_valid = 0; p_ready = 0;
        p_addr = '0; p_data = '0;
        for (int cyc = 0; cyc < 40000 && !done; cyc++) begin
            bus.out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            @(negedge clk);
            if (bus.out_valid && first_valid < 0) first_valid = cyc;
            if (p_valid && !p_ready)
                chk("stall_hold", {bus.out_valid, bus.out_addr, bus.out_data}, {1'b1, p_addr, p_data});
            if (bus.out_valid && bus.out_ready) begin
                chk("dump_addr", bus.out_addr, exp_addr);
                chk("dump_data", bus.out_data, exp_q.pop_front());
                chk("dump_done_early", bus.dump_done, 0);
                if (exp_addr == stop_addr) done = 1;
                exp_addr++;
            end
            p_valid = bus.out_valid; p_ready = bus.out_ready;
            p_addr = bus.out_addr;   p_data = bus.out_data;
            tick();
        end
        bus.out_ready = 0;
        if (!done) chk("dump_timeout", exp_addr, stop_addr + 1);
        chk("first_valid_latency", (first_valid >= 0) && (first_valid <= 3), 1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rd_tab[0] = '{addr: 14'h0081, req: 1'b1, exp: 8'h81};
        rd_tab[1] = '{addr: 14'h0123, req: 1'b0, exp: 8'h81};
        rd_tab[2] = '{addr: 14'h3FFF, req: 1'b1, exp: 8'hFF};
        rd_tab[3] = '{addr: 14'h1234, req: 1'b1, exp: 8'h34};
        rd_tab[4] = '{addr: 14'h2000, req: 1'b0, exp: 8'h34};
        rd_tab[5] = '{addr: 14'h0000, req: 1'b1, exp: 8'h00};
        for (int a = 0; a < N; a++) lbp_model[a] = 8'h00;

        // ---- run 1: full load, reads, interior writes, reset mid-dump ----
        do_reset();
        bus.load_last = 1;
        tick();
        bus.load_last = 0;
        chk("last_without_valid_state", dbg_state, 0);
        for (int a = 0; a < N; a++) begin
            if (a == 8000) chk("gray_ready_in_load", bus.gray_ready, 0);
            load_beat(a, a[7:0], a == N - 1);
        end
        chk("gray_ready_after_load", bus.gray_ready, 1);
        chk("state_serve", dbg_state, 1);
        chk("err_after_load", bus.err, 0);

        foreach (rd_tab[i]) begin
            bus.gray_req  = rd_tab[i].req;
            bus.gray_addr = rd_tab[i].addr;
            tick();
            chk("gray_read_vec", bus.gray_data, rd_tab[i].exp);
        end
        bus.gray_req = 0;

        for (int r = 1; r <= 126; r++)
            for (int c = 1; c <= 126; c++) begin
                lbp_model[r * 128 + c] = 8'hA5;
                lbp_write(r * 128 + c, 8'hA5, (r == 126) && (c == 126));
            end
        chk("state_dump", dbg_state, 2);
        chk("wr_count_interior", bus.wr_count, 15876);
        chk("err_interior", bus.err, 0);
        chk("gray_ready_in_dump", bus.gray_ready, 0);
        run_dump(1'b0, 300);

        reset = 1;
        #1;
        chk("midrst_out_valid",  bus.out_valid, 0);
        chk("midrst_dump_done",  bus.dump_done, 0);
        chk("midrst_wr_count",   bus.wr_count, 0);
        chk("midrst_state",      dbg_state, 0);
        chk("midrst_gray_ready", bus.gray_ready, 0);
        @(negedge clk);
        reset = 0;
        tick();

        // ---- run 2: reload, border write error, backpressured full dump ----
        load_beat(14'h0081, 8'h81, 1'b1);
        chk("reload_gray_ready", bus.gray_ready, 1);
        chk("reload_err", bus.err, 0);
        bus.gray_req = 1; bus.gray_addr = 14'h0081;
        tick();
        bus.gray_req = 0;
        chk("reload_read", bus.gray_data, 8'h81);
        lbp_model[5] = 8'h77;
        lbp_write(14'h0005, 8'h77, 1'b0);
        chk("border_write_err", bus.err, 1);
        chk("border_write_count", bus.wr_count, 1);
        lbp_model[14'h0181] = 8'h3C;
        lbp_write(14'h0181, 8'h3C, 1'b0);
        bus.finish = 1;
        tick();
        bus.finish = 0;
        chk("run2_wr_count", bus.wr_count, 2);
        chk("run2_state_dump", dbg_state, 2);
        run_dump(1'b1, N - 1);
        chk("final_out_valid", bus.out_valid, 0);
        chk("final_dump_done", bus.dump_done, 1);
        chk("final_state", dbg_state, 3);
        bus.gray_req = 1; bus.gray_addr = 14'h3FFF; bus.finish = 1; bus.out_ready = 1;
        tick();
        tick();
        idle_inputs();
        chk("done_gray_hold", bus.gray_data, 8'h81);
        chk("done_sticky_state", dbg_state, 3);
        chk("done_no_valid", bus.out_valid, 0);

        // ---- run 3: result write during LOAD is dropped ----
        do_reset();
        lbp_write(200, 8'h11, 1'b0);
        chk("load_lbp_err", bus.err, 1);
        chk("load_lbp_count", bus.wr_count, 0);
        load_beat(14'h0081, 8'h81, 1'b1);
        bus.finish = 1;
        tick();
        bus.finish = 0;
        run_dump(1'b0, 300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
